// File: rtl/blk_inv_pkg.sv
// Shared types for the block-LU inversion sequencer: FSM states, row-bank and mul-pass encodings.
package blk_inv_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_LU0_GO, S_LU0_WAIT, S_LINV_GO, S_LINV_WAIT, S_UINV_GO, S_UINV_WAIT,
      S_MUL_U12, S_MUL_L21, S_MUL_SCHUR, S_LU1_GO, S_LU1_WAIT, S_DONE
   } state_e;

   typedef enum logic [1:0] {BANK_A00, BANK_L, BANK_U, BANK_SCHUR} bank_e;

   typedef enum logic [1:0] {PASS_U12, PASS_L21, PASS_SCHUR} pass_e;

   // Index width for a SIZE x SIZE block; never narrower than one bit.
   function automatic int idx_w(input int size);
      return (size > 2) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/blk_inv_idx_cnt.sv
// 2-D (row, col) element counter, col fastest; wraps to (0,0) after (SIZE-1, SIZE-1).
module blk_inv_idx_cnt
   import blk_inv_pkg::*;
#(
   parameter  int SIZE = 16,
   localparam int W    = idx_w(SIZE)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_row,
   output logic [W-1:0] o_col,
   output logic         o_last
);
   localparam logic [W-1:0] MAXI = W'(SIZE - 1);

   logic [W-1:0] r_row, r_col;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (r_col == MAXI) begin
            r_col <= '0;
            r_row <= (r_row == MAXI) ? '0 : r_row + W'(1);
         end else begin
            r_col <= r_col + W'(1);
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = (r_row == MAXI) && (r_col == MAXI);

endmodule

// File: rtl/blk_inv_seq.sv
// Block-LU inversion phase sequencer: starts lu / triang_matrix_inv, selects row bank, streams mul indices.
// Optional per-wait watchdog with sticky err_o: define BLK_INV_TIMEOUT_EN.
module blk_inv_seq
   import blk_inv_pkg::*;
#(
   parameter  int SIZE        = 16,
   parameter  int TIMEOUT_CYC = 4096,
   localparam int W           = idx_w(SIZE)
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         flush_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [1:0]   bank_sel_o,
   output logic         lu_start_o,
   input  logic         lu_in_ready_i,
   output logic         tinv_start_o,
   input  logic         tinv_in_ready_i,
   output logic         mul_in_valid_o,
   input  logic         mul_in_ready_i,
   output logic [W-1:0] mul_row_o,
   output logic [W-1:0] mul_col_o,
   output logic [1:0]   mul_pass_o,
   input  logic         mul_out_valid_i,
   output logic         mul_out_ready_o,
   output logic         wb_valid_o,
   output logic [W-1:0] wb_row_o,
   output logic [W-1:0] wb_col_o,
   output logic         wb_sub_o,
   output logic         err_o
);
   localparam int CW = 2*W + 1;

   state_e        r_state, w_nxt;
   logic          r_seen_low, r_iss_done, r_ret_done;
   logic [CW-1:0] r_pend;
   logic          w_in_wait, w_in_mul, w_ready, w_wait_exit, w_pass_end, w_timeout, w_clr;
   logic          w_iss_acc, w_ret_acc, w_iss_last, w_ret_last;

   assign w_in_wait   = r_state inside {S_LU0_WAIT, S_LINV_WAIT, S_UINV_WAIT, S_LU1_WAIT};
   assign w_in_mul    = r_state inside {S_MUL_U12, S_MUL_L21, S_MUL_SCHUR};
   assign w_ready     = (r_state inside {S_LU0_WAIT, S_LU1_WAIT}) ? lu_in_ready_i : tinv_in_ready_i;
   // Only a rise after the engine has been seen busy counts as completion.
   assign w_wait_exit = w_in_wait & r_seen_low & w_ready;
   assign w_pass_end  = w_in_mul & r_ret_done;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:      if (start_i) w_nxt = S_LU0_GO;
         S_LU0_GO:    w_nxt = S_LU0_WAIT;
         S_LU0_WAIT:  if (w_wait_exit) w_nxt = S_LINV_GO;
         S_LINV_GO:   w_nxt = S_LINV_WAIT;
         S_LINV_WAIT: if (w_wait_exit) w_nxt = S_UINV_GO;
         S_UINV_GO:   w_nxt = S_UINV_WAIT;
         S_UINV_WAIT: if (w_wait_exit) w_nxt = S_MUL_U12;
         S_MUL_U12:   if (w_pass_end) w_nxt = S_MUL_L21;
         S_MUL_L21:   if (w_pass_end) w_nxt = S_MUL_SCHUR;
         S_MUL_SCHUR: if (w_pass_end) w_nxt = S_LU1_GO;
         S_LU1_GO:    w_nxt = S_LU1_WAIT;
         S_LU1_WAIT:  if (w_wait_exit) w_nxt = S_DONE;
         S_DONE:      w_nxt = S_IDLE;
         default:     w_nxt = S_IDLE;
      endcase
      if (w_timeout) w_nxt = S_IDLE;
      if (flush_i)   w_nxt = S_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_seen_low <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (!w_in_wait || (w_nxt != r_state)) r_seen_low <= 1'b0;
         else if (!w_ready)                    r_seen_low <= 1'b1;
      end
   end

   // Issue/return bookkeeping restarts at every pass boundary, so passes never overlap.
   assign w_clr     = ~w_in_mul | (w_nxt != r_state);
   assign w_iss_acc = mul_in_valid_o & mul_in_ready_i;
   assign w_ret_acc = mul_out_valid_i & w_in_mul & (r_pend != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend     <= '0;
         r_iss_done <= 1'b0;
         r_ret_done <= 1'b0;
      end else if (w_clr) begin
         r_pend     <= '0;
         r_iss_done <= 1'b0;
         r_ret_done <= 1'b0;
      end else begin
         if (w_iss_acc && !w_ret_acc)      r_pend <= r_pend + CW'(1);
         else if (!w_iss_acc && w_ret_acc) r_pend <= r_pend - CW'(1);
         if (w_iss_acc && w_iss_last) r_iss_done <= 1'b1;
         if (w_ret_acc && w_ret_last) r_ret_done <= 1'b1;
      end
   end

   blk_inv_idx_cnt #(.SIZE(SIZE)) u_iss_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clr   (w_clr),
      .i_inc   (w_iss_acc),
      .o_row   (mul_row_o),
      .o_col   (mul_col_o),
      .o_last  (w_iss_last)
   );

   blk_inv_idx_cnt #(.SIZE(SIZE)) u_ret_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clr   (w_clr),
      .i_inc   (w_ret_acc),
      .o_row   (wb_row_o),
      .o_col   (wb_col_o),
      .o_last  (w_ret_last)
   );

`ifdef BLK_INV_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_to_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (flush_i)        r_err <= 1'b0;
         else if (w_timeout) r_err <= 1'b1;
         if (!w_in_wait || (w_nxt != r_state)) r_to_cnt <= '0;
         else                                  r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   assign w_timeout = w_in_wait & ~w_wait_exit & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
   assign err_o     = r_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYC != 0);
   assign w_timeout        = 1'b0;
   assign err_o            = 1'b0;
`endif

   always_comb begin
      bank_sel_o = BANK_A00;
      case (r_state)
         S_LINV_GO, S_LINV_WAIT: bank_sel_o = BANK_L;
         S_UINV_GO, S_UINV_WAIT: bank_sel_o = BANK_U;
         S_LU1_GO, S_LU1_WAIT:   bank_sel_o = BANK_SCHUR;
         default:                bank_sel_o = BANK_A00;
      endcase
   end

   always_comb begin
      mul_pass_o = PASS_U12;
      case (r_state)
         S_MUL_L21:   mul_pass_o = PASS_L21;
         S_MUL_SCHUR: mul_pass_o = PASS_SCHUR;
         default:     mul_pass_o = PASS_U12;
      endcase
   end

   assign busy_o          = (r_state != S_IDLE);
   assign done_o          = (r_state == S_DONE) & ~flush_i;
   assign lu_start_o      = (r_state == S_LU0_GO) | (r_state == S_LU1_GO);
   assign tinv_start_o    = (r_state == S_LINV_GO) | (r_state == S_UINV_GO);
   assign mul_in_valid_o  = w_in_mul & ~r_iss_done;
   assign mul_out_ready_o = w_in_mul;
   assign wb_valid_o      = w_ret_acc;
   assign wb_sub_o        = (r_state == S_MUL_SCHUR);

endmodule
